serial_word_tx: RTL and testbench
=================================

# serial_word_tx

Parallel-to-serial word transmitter that drives the bit-serial, LSB-first two's-complement datapath. It accepts one WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on `seqout`, LSB first. Before every word it asserts the frame-clear strobe `frm_clr`, which is wired to the synchronous reset of the downstream serial complementer so that the complementer starts each word in its initial state. It is the producer end of the serial stream that the complementer FSM consumes.

## Interface
- `WIDTH`, default 8: word length in bits; legal range 2..32.
- `clk`  input  1  rising-edge clock; the only clock in the block.
- `reset`  input  1  synchronous, active-high reset.
- `din`  input  WIDTH  parallel word to send.
- `din_valid`  input  1  `din` is valid.
- `din_ready`  output  1  block accepts `din` this cycle.
- `seqout`  output  1  serial data bit, LSB first.
- `seq_valid`  output  1  `seqout` carries a data bit this cycle.
- `last`  output  1  current bit is bit WIDTH-1, the MSB.
- `frm_clr`  output  1  frame clear; drives the downstream serial FSM reset.
- `busy`  output  1  a word is in flight (state is CLR or SHIFT).

## Operation
- FSM states: IDLE, CLR, SHIFT. All registers are updated only on the rising edge of `clk`.
- **IDLE**
  - `din_ready`=1.
  - A transfer occurs on a clock edge where `din_valid` & `din_ready` are both 1.
  - On a transfer: load `din` into the WIDTH-bit shift register, clear the bit counter, and go to CLR.
- **CLR**
  - Lasts exactly 1 cycle, then go to SHIFT.
  - `din_ready`=0, `seq_valid`=0.
- **SHIFT**
  - `seqout` = sreg[0] and `seq_valid`=1.
  - Each cycle: shift the register right by one and increment the counter.
  - `last`=1 when counter = WIDTH-1.
  - On the last cycle, `din_ready`=1:
    - If a transfer occurs, load the new word and go to CLR (back-to-back operation).
    - Otherwise go to IDLE.
- Output decode:
  - `frm_clr`=1 in IDLE and CLR, 0 in SHIFT. This guarantees at least one clear cycle before bit 0.
  - `busy`=1 in CLR and SHIFT.
- `seqout` is 0 whenever `seq_valid`=0.
- `din` is sampled only on a transfer edge. Changes to `din` at any other time have no effect.
- `din_valid` while `din_ready`=0 (CLR, or SHIFT before the last bit) is ignored, and no word is captured. The source must hold `din_valid` and `din` until it sees `din_ready`.
- The counter width is $clog2(WIDTH). The counter never wraps past WIDTH-1.

## Timing
- Reset values (cycle after `reset` is sampled high):
  - state=IDLE, `din_ready`=1, `frm_clr`=1.
  - `seq_valid`=0, `seqout`=0, `last`=0, `busy`=0.
  - sreg=0, counter=0.
- While `reset` is high: `din_ready` is forced to 0, and no transfer occurs.
- `reset` mid-word: the word is abandoned. The next cycle is in IDLE with the reset values above. No partial bits are emitted after reset.
- Latency, for a transfer at edge T:
  - CLR is the cycle after T.
  - Bit 0 appears in cycle T+2.
  - Bit WIDTH-1, with `last`=1, appears in cycle T+WIDTH+1.
- Throughput: one word per WIDTH+1 cycles when back-to-back (1 CLR cycle + WIDTH data cycles).
- All outputs are decoded from registered state and register contents only. There is no combinational path from `din_valid` to any output except `din_ready`, and `din_ready` itself does not depend on `din_valid`.

## Structure
- Shared package `serial_pkg`:
  - State encoding constants for IDLE/CLR/SHIFT.
  - Default WIDTH constant, shared with the complementer-side receivers.
- Natural sub-module: `serial_bit_counter`. It is a WIDTH-parameterised up-counter with a clear input and a terminal-count (`last`) output. It is reused by the serial receivers.
- Shift register and FSM live in the top module.

## Test plan
- Reset, then `din`=8'h05 with a single-cycle `din_valid` (WIDTH=8):
  - `frm_clr`=1 for the CLR cycle.
  - `seqout` sequence 1,0,1,0,0,0,0,0 with `seq_valid`=1 for 8 cycles.
  - `last` high only on the 8th bit.
  - Returns to IDLE afterwards.
- Chain with the serial complementer (its `reset` driven by `frm_clr`), `din`=8'h05: complementer output bits assemble to 8'hFB. Repeat with 8'h80, expecting 8'h80, and with 8'h00, expecting 8'h00.
- Back-to-back, with `din_valid` held high and words 8'hA5 then 8'h3C:
  - Second transfer occurs on the `last` cycle of the first word.
  - Exactly one CLR cycle between the words.
  - Total of 18 cycles from the first transfer to the second `last`.
- Hold `din_valid`=1 with `din`=8'h11 during CLR and mid-SHIFT of word 8'hFF:
  - 8'h11 is not captured until the `last` cycle.
  - Word 8'hFF is emitted intact.
- Assert `reset` in SHIFT after 3 bits of 8'hF0:
  - Next cycle is IDLE with `seq_valid`=0, `frm_clr`=1, `din_ready`=1.
  - A new word 8'h01 sends correctly, bits 1,0,0,0,0,0,0,0.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial LSB-first datapath.
// Holds the transmitter state encoding and the default word length used by
// both the word transmitter and the complementer-side receivers.
package serial_pkg;

  localparam int SERIAL_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLR   = 2'd1,
    ST_SHIFT = 2'd2
  } tx_state_t;

endpackage

// File: rtl/serial_bit_counter.sv
// Bit-position counter for serial words.
// Counts up while en is high and stops at WIDTH-1 (never wraps); clr forces
// it back to zero and takes priority over en.
// Ports:
//   clk   - rising-edge clock
//   clr   - synchronous clear
//   en    - advance one bit position
//   last  - count has reached WIDTH-1
import serial_pkg::*;

module serial_bit_counter #(
  parameter int WIDTH = SERIAL_WIDTH
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en && !last) begin
      count <= count + 1'b1;
    end
  end

  assign last = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter, LSB first.
// Accepts one WIDTH-bit word over valid/ready, spends one CLR cycle with
// frm_clr high so the downstream serial FSM restarts, then shifts out WIDTH
// bits. A new word may be accepted on the last bit for back-to-back frames.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   din, din_valid       - parallel word and its valid
//   din_ready            - word accepted this cycle when din_valid is high
//   seqout, seq_valid    - serial data bit and its qualifier
//   last                 - current bit is the MSB
//   frm_clr              - frame clear for the downstream serial FSM
//   busy                 - a word is in flight
import serial_pkg::*;

module serial_word_tx #(
  parameter int WIDTH = SERIAL_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             seqout,
  output logic             seq_valid,
  output logic             last,
  output logic             frm_clr,
  output logic             busy
);

  tx_state_t        state;
  tx_state_t        state_nxt;
  logic [WIDTH-1:0] sreg;
  logic             cnt_last;
  logic             xfer;
  logic             in_shift;

  assign in_shift = (state == ST_SHIFT);
  assign xfer     = din_valid & din_ready;

  // Counter sits at zero outside SHIFT, so bit 0 always starts from a clean count.
  serial_bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .clk  (clk),
    .clr  (reset | ~in_shift),
    .en   (in_shift),
    .last (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // din_ready depends only on state, counter and reset, never on din_valid.
  always_comb begin
    din_ready = 1'b0;
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        din_ready = ~reset;
      end
      ST_CLR: begin
        state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        din_ready = ~reset & cnt_last;
        if (cnt_last) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    if (din_valid && din_ready) begin
      state_nxt = ST_CLR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg <= '0;
    end else if (xfer) begin
      sreg <= din;
    end else if (in_shift) begin
      sreg <= sreg >> 1;
    end
  end

  assign seq_valid = in_shift;
  assign seqout    = in_shift & sreg[0];
  assign last      = in_shift & cnt_last;
  assign frm_clr   = ~in_shift;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx (WIDTH=8): directed frames plus randomized traffic,
// checked cycle by cycle against a queue of expected per-cycle outputs, with a
// behavioural serial complementer and deserializer attached to the outputs.
module tb_serial_word_tx;
  import serial_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic sv;
    logic so;
    logic lst;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         seqout;
  logic         seq_valid;
  logic         last;
  logic         frm_clr;
  logic         busy;

  serial_word_tx #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .seqout    (seqout),
    .seq_valid (seq_valid),
    .last      (last),
    .frm_clr   (frm_clr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;
  exp_t         q[$];
  int           xfer_cyc[$];
  int           last_cyc[$];
  int           bit_idx = 0;
  logic         cm_seen = 1'b0;
  logic [W-1:0] rx_acc, rx_word, cm_acc, cm_word;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] neg(input logic [W-1:0] w);
    logic [W-1:0] z;
    z = '0;
    return z - w;
  endfunction

  // One clock cycle: drive inputs, check outputs at negedge, advance model at posedge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r);
    exp_t e;
    logic ex_rdy;
    logic mdl_xfer;
    din_valid = v;
    din       = d;
    reset     = r;
    @(negedge clk);
    cyc++;
    e      = (q.size() != 0) ? q[0] : exp_t'('0);
    ex_rdy = !r && (q.size() == 0 || e.lst);
    check("din_ready", din_ready, ex_rdy);
    check("seq_valid", seq_valid, e.sv);
    check("seqout",    seqout,    e.so);
    check("last",      last,      e.lst);
    check("frm_clr",   frm_clr,   !e.sv);
    check("busy",      busy,      q.size() != 0);
    mdl_xfer = v && ex_rdy;

    if (din_valid && din_ready) xfer_cyc.push_back(cyc);
    if (last) last_cyc.push_back(cyc);
    if (frm_clr) begin
      bit_idx = 0;
      cm_seen = 1'b0;
    end else if (seq_valid && bit_idx < W) begin
      rx_acc[bit_idx] = seqout;
      cm_acc[bit_idx] = seqout ^ cm_seen;
      if (seqout) cm_seen = 1'b1;
      bit_idx++;
      if (last) begin
        rx_word = rx_acc;
        cm_word = cm_acc;
      end
    end

    @(posedge clk);
    if (q.size() != 0) void'(q.pop_front());
    if (r) q.delete();
    if (mdl_xfer) begin
      q.push_back(exp_t'('0));
      for (int i = 0; i < W; i++) q.push_back('{sv: 1'b1, so: d[i], lst: (i == W - 1)});
    end
    #1;
  endtask

  task automatic send(input logic [W-1:0] w, input string tag);
    rx_word = 'x;
    cm_word = 'x;
    xfer_cyc.delete();
    last_cyc.delete();
    step(1'b1, w, 1'b0);
    repeat (W + 2) step(1'b0, W'($urandom), 1'b0);
    check({tag, "_rx"}, rx_word, w);
    check({tag, "_cmp"}, cm_word, neg(w));
    check({tag, "_nlast"}, last_cyc.size(), 1);
    if (xfer_cyc.size() == 1 && last_cyc.size() == 1)
      check({tag, "_lat"}, last_cyc[0] - xfer_cyc[0], W + 1);
  endtask

  initial begin
    reset     = 1'b1;
    din_valid = 1'b0;
    din       = '0;
    repeat (2) @(posedge clk);
    #1;
    step(1'b1, 8'h5A, 1'b1);
    step(1'b0, '0, 1'b0);

    send(8'h05, "w05");
    send(8'h80, "w80");
    send(8'h00, "w00");

    xfer_cyc.delete();
    last_cyc.delete();
    step(1'b1, 8'hA5, 1'b0);
    repeat (W + 1) step(1'b1, 8'h3C, 1'b0);
    repeat (W + 2) step(1'b0, '0, 1'b0);
    check("b2b_nxfer", xfer_cyc.size(), 2);
    check("b2b_nlast", last_cyc.size(), 2);
    if (xfer_cyc.size() == 2 && last_cyc.size() == 2) begin
      check("b2b_onlast", xfer_cyc[1], last_cyc[0]);
      check("b2b_total", last_cyc[1] - xfer_cyc[0], 2 * W + 2);
    end
    check("b2b_rx", rx_word, 8'h3C);

    xfer_cyc.delete();
    last_cyc.delete();
    step(1'b1, 8'hFF, 1'b0);
    repeat (W + 1) step(1'b1, 8'h11, 1'b0);
    check("hold_ff", rx_word, 8'hFF);
    repeat (W + 2) step(1'b0, '0, 1'b0);
    check("hold_11", rx_word, 8'h11);
    if (xfer_cyc.size() == 2 && last_cyc.size() == 2)
      check("hold_when", xfer_cyc[1], last_cyc[0]);
    else
      check("hold_nxfer", xfer_cyc.size(), 2);

    step(1'b1, 8'hF0, 1'b0);
    repeat (4) step(1'b0, '0, 1'b0);
    step(1'b1, 8'h77, 1'b1);
    reset     = 1'b0;
    din_valid = 1'b0;
    #1;
    check("rst_sv", seq_valid, 1'b0);
    check("rst_clr", frm_clr, 1'b1);
    check("rst_rdy", din_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    send(8'h01, "w01");

    repeat (400) begin
      step($urandom_range(0, 2) != 0, W'($urandom), $urandom_range(0, 49) == 0);
    end
    repeat (W + 2) step(1'b0, '0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
